// File: rtl/alu_datapath.sv
// rtl/alu_datapath.sv - single-cycle registered ALU with truth-table operand and flags
// Optional signed-overflow flag: define ALU_OVERFLOW_FLAG_EN.
module alu_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             AC0_RHS0,
  input  logic             AC1_RHS1,
  input  logic             AC2_RHS2,
  input  logic             AC3_RHS3,
  input  logic             AC4_LHS0,
  input  logic             AC5_LHS1,
  input  logic             AC6_CS0,
  input  logic             AC7_CS1,
  input  logic             AluActive,
  input  logic [WIDTH-1:0] LhsIn,
  input  logic [WIDTH-1:0] RhsIn,
  input  logic             FlagsLoad,
  input  logic [3:0]       FlagsIn,
  output logic [WIDTH-1:0] Result,
  output logic             ResultValid,
  output logic             FlagC,
  output logic             FlagZ,
  output logic             FlagS,
  output logic             FlagV
);

  logic [3:0]       rhs_tt;
  logic [1:0]       lhs_mode;
  logic [1:0]       cs_sel;
  logic [WIDTH-1:0] f_op;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d;
  logic             flag_c_q, flag_z_q, flag_s_q, valid_q;

  assign rhs_tt   = {AC3_RHS3, AC2_RHS2, AC1_RHS1, AC0_RHS0};
  assign lhs_mode = {AC5_LHS1, AC4_LHS0};
  assign cs_sel   = {AC7_CS1, AC6_CS0};

  // Each operand bit selects one of four truth-table entries by {B[i],A[i]}.
  always_comb begin
    f_op = '0;
    for (int i = 0; i < WIDTH; i++) begin
      f_op[i] = rhs_tt[{RhsIn[i], LhsIn[i]}];
    end
  end

  always_comb begin
    cin = 1'b0;
    case (cs_sel)
      2'b01:   cin = flag_c_q;
      2'b10:   cin = 1'b1;
      default: cin = 1'b0;
    endcase
  end

  assign sum = {1'b0, LhsIn} + {1'b0, f_op} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    result_d = sum[WIDTH-1:0];
    carry_d  = sum[WIDTH];
    case (lhs_mode)
      2'b01: begin
        result_d = {LhsIn[WIDTH-2:0], 1'b0};
        carry_d  = LhsIn[WIDTH-1];
      end
      2'b10: begin
        result_d = {1'b0, LhsIn[WIDTH-1:1]};
        carry_d  = LhsIn[0];
      end
      2'b11: begin
        result_d = f_op;
        carry_d  = 1'b0;
      end
      default: begin
        result_d = sum[WIDTH-1:0];
        carry_d  = sum[WIDTH];
      end
    endcase
  end

  // An issued op always takes priority over a flags restore.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      result_q <= '0;
      valid_q  <= 1'b0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_s_q <= 1'b0;
    end else if (AluActive) begin
      result_q <= result_d;
      valid_q  <= 1'b1;
      flag_c_q <= carry_d;
      flag_z_q <= (result_d == '0);
      flag_s_q <= result_d[WIDTH-1];
    end else begin
      valid_q <= 1'b0;
      if (FlagsLoad) begin
        flag_c_q <= FlagsIn[0];
        flag_z_q <= FlagsIn[1];
        flag_s_q <= FlagsIn[2];
      end
    end
  end

`ifdef ALU_OVERFLOW_FLAG_EN
  logic ovf_d, flag_v_q;

  assign ovf_d = (lhs_mode == 2'b00) && (LhsIn[WIDTH-1] == f_op[WIDTH-1]) &&
                 (result_d[WIDTH-1] != LhsIn[WIDTH-1]);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      flag_v_q <= 1'b0;
    end else if (AluActive) begin
      flag_v_q <= ovf_d;
    end else if (FlagsLoad) begin
      flag_v_q <= FlagsIn[3];
    end
  end

  assign FlagV = flag_v_q;
`else
  logic unused_flags_v;
  assign unused_flags_v = FlagsIn[3];
  assign FlagV          = 1'b0;
`endif

  assign Result      = result_q;
  assign ResultValid = valid_q;
  assign FlagC       = flag_c_q;
  assign FlagZ       = flag_z_q;
  assign FlagS       = flag_s_q;

endmodule

// File: doc/alu_datapath.md
ALU_DATAPATH -- requirements
Module: alu_datapath

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits (legal range 2..16).
REQ-002 Clock  in  1  system clock; all state on rising edge.
REQ-003 Reset  in  1  asynchronous, active-high; clears all state.
REQ-004 AC0_RHS0..AC3_RHS3  in  1 each  RHS truth-table bits R[3:0].
REQ-005 AC4_LHS0, AC5_LHS1  in  1 each  LHS mode L[1:0].
REQ-006 AC6_CS0, AC7_CS1  in  1 each  carry-in select C[1:0].
REQ-007 AluActive  in  1  operation issue strobe; sampled each rising edge.
REQ-008 LhsIn  in  WIDTH  operand A.
REQ-009 RhsIn  in  WIDTH  operand B.
REQ-010 FlagsLoad  in  1  load flags from FlagsIn (context restore).
REQ-011 FlagsIn  in  4  {V,S,Z,C} restore value.
REQ-012 Result  out  WIDTH  registered result.
REQ-013 ResultValid  out  1  one-cycle pulse, Result updated this cycle.
REQ-014 FlagC, FlagZ, FlagS, FlagV  out  1 each  registered carry, zero, sign, overflow.

Function
REQ-015 Bitwise operand F[i] SHALL be R[{B[i],A[i]}] (index = 2*B[i]+A[i]).
REQ-016 Carry-in SHALL be: C=00 -> 0; C=01 -> current FlagC; C=10 -> 1; C=11 -> 0.
REQ-017 L=00 (add): sum = A + F + cin over WIDTH+1 bits; Result = sum[WIDTH-1:0]; carry = sum[WIDTH].
REQ-018 L=01 (shl): Result = {A[WIDTH-2:0],0}; carry = A[WIDTH-1]; F and cin ignored.
REQ-019 L=10 (shr): Result = {0,A[WIDTH-1:1]}; carry = A[0]; F and cin ignored.
REQ-020 L=11 (logic): Result = F; carry = 0.
REQ-021 Z = (new Result == 0); S = new Result[WIDTH-1].
REQ-022 Latency: AluActive high at edge N -> Result, flags, ResultValid=1 visible after edge N; ResultValid low after edge N+1 unless AluActive high again.
REQ-023 AluActive low: Result and all flags SHALL hold; ResultValid=0.
REQ-024 Back-to-back issues SHALL be supported every cycle; C=01 SHALL use FlagC produced by the immediately preceding op (no bubble).
REQ-025 FlagsLoad high, AluActive low: flags <= FlagsIn after edge; Result unchanged; ResultValid=0.
REQ-026 FlagsLoad and AluActive both high: ALU op SHALL win; FlagsIn ignored.
REQ-027 Control lines and operands are sampled only at edges where AluActive is high; values at other times SHALL have no effect.

Reset
REQ-028 Reset high: Result=0, ResultValid=0, FlagC=FlagZ=FlagS=FlagV=0, immediately and independent of Clock.
REQ-029 Reset asserted while AluActive is high: op discarded; first op after release sees FlagC=0.
REQ-030 Reset deassertion SHALL produce no ResultValid pulse.

Configuration
REQ-031 Macro ALU_OVERFLOW_FLAG_EN defined: FlagV = signed overflow for L=00 (A[MSB]==F[MSB] && Result[MSB]!=A[MSB]); V=0 for L=01/10/11; FlagsIn[3] loadable.
REQ-032 Macro not defined: FlagV tied 0, no overflow logic/register, FlagsIn[3] ignored.

Verification
REQ-033 ADD: L=00,R=1100,C=00, A=0xF0,B=0x20 -> Result 0x10, C=1, Z=0, S=0, ResultValid one cycle.
REQ-034 ADD then ADDC chain: A=0xFF,B=0x01 (ADD) then A=0x00,B=0x00,C=01 -> Results 0x00(C=1,Z=1), 0x01(C=0), consecutive cycles.
REQ-035 SUB: R=0011,C=10, A=0x05,B=0x07 -> Result 0xFE, C=0, S=1; with ALU_OVERFLOW_FLAG_EN, A=0x80,B=0x01 -> Result 0x7F, V=1.
REQ-036 Shifts/logic: SHL A=0x81 -> 0x02,C=1; SHR A=0x81 -> 0x40,C=1; XOR R=0110 A=0x0F,B=0xFF -> 0xF0,C=0; CLC R=0000 -> 0x00,C=0,Z=1.
REQ-037 FlagsLoad: FlagsIn=4'b0001, AluActive=0 -> FlagC=1, Result held; same cycle AluActive=1 with CLC -> FlagC=0.
REQ-038 Reset mid-stream: assert Reset between edges during ADD burst -> all outputs 0 immediately; INCC (C=01,R=0000) A=0x00 after release -> 0x00.
